// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller: sequences a WIDTH-bit add through one shared
// 4-bit ripple adder, LSB nibble first, with the carry chained in a register.
module nibble_serial_add_ctrl #(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  input  logic                   cin,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [3:0]             add_a,
  output logic [3:0]             add_b,
  output logic                   add_cin,
  input  logic [3:0]             add_sum,
  input  logic                   add_carry
);

  localparam int unsigned WIDTH = 4 * NIBBLES;
  localparam int unsigned IDXW  = $clog2(NIBBLES);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NIBBLES - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              cin_q, cin_d;
  logic              carry_q, carry_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;
  logic [IDXW+1:0]   base;

  // Bit offset of the nibble currently being processed.
  assign base = {idx_q, 2'b00};

  assign busy = (state_q == RUN);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic and adder drive; adder inputs come only from registers.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          cin_d   = cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[base +: 4];
        add_b   = b_q[base +: 4];
        add_cin = (idx_q == '0) ? cin_q : carry_q;
        sum_d[base +: 4] = add_sum;
        carry_d = add_carry;
        idx_d   = idx_q + IDXW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = add_carry;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_sum[3] != a_q[WIDTH-1]);
          state_d = IDLE;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Bench for nibble_serial_add_ctrl with NIBBLES=4 and a behavioural 4-bit adder.
module tb_nibble_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  logic [3:0]  add_a, add_b, add_sum;
  logic        add_cin, add_carry;
  logic [4:0]  add_res;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];

  nibble_serial_add_ctrl #(.NIBBLES(4)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_carry(add_carry)
  );

  // Shared 4-bit ripple adder stand-in.
  assign add_res   = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};
  assign add_sum   = add_res[3:0];
  assign add_carry = add_res[4];

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    exp_t e;
    logic [16:0] r;
    r   = {1'b0, x} + {1'b0, y} + {16'b0, ci};
    e.s = r[15:0];
    e.c = r[16];
    e.o = (x[15] == y[15]) && (r[15] != x[15]);
    return e;
  endfunction

  // Scoreboard: each done pulse retires the oldest expected result.
  logic prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset && done) begin
      check_eq("done_single", {31'b0, prev_done}, 32'd0);
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_eq("sum",  {16'b0, sum}, {16'b0, e.s});
        check_eq("cout", {31'b0, cout}, {31'b0, e.c});
        check_eq("ovf",  {31'b0, ovf},  {31'b0, e.o});
      end
    end
    prev_done = done;
  end

  // Counts negedges until done is seen; n==5 means done after the 4th RUN edge.
  task automatic wait_done(input bit chk_cin, output int n, output int busy_n);
    n = 0;
    busy_n = 0;
    while (1) begin
      @(negedge clk);
      n++;
      if (busy) busy_n++;
      if (chk_cin && busy) check_eq("add_cin_run", {31'b0, add_cin}, 32'd1);
      if (done) break;
      if (n >= 20) begin
        check_eq("done_timeout", 32'd1, 32'd0);
        break;
      end
    end
  endtask

  task automatic run_add(input logic [15:0] x, input logic [15:0] y, input logic ci,
                         input bit chk_cin, output int n, output int busy_n);
    @(posedge clk); #1;
    a = x; b = y; cin = ci; start = 1'b1;
    exp_q.push_back(model(x, y, ci));
    @(posedge clk); #1;
    start = 1'b0;
    a = ~x; b = ~y; cin = ~ci;
    wait_done(chk_cin, n, busy_n);
  endtask

  initial begin
    int n, bn;
    exp_t e;
    reset = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #12;
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_done", {31'b0, done}, 32'd0);
    check_eq("rst_sum",  {16'b0, sum},  32'd0);
    check_eq("rst_addin", {23'b0, add_a, add_b, add_cin}, 32'd0);
    reset = 1'b0;

    // 1: basic add, latency and busy length
    run_add(16'h1234, 16'h4321, 1'b0, 1'b0, n, bn);
    check_eq("t1_latency", n - 1, 32'd4);
    check_eq("t1_busy_cycles", bn, 32'd4);
    @(negedge clk);
    check_eq("t1_done_low", {31'b0, done}, 32'd0);
    check_eq("t1_sum_hold", {16'b0, sum}, 32'h5555);
    check_eq("t1_idle_adda", {28'b0, add_a}, 32'd0);

    // 2: full carry ripple, add_cin high in every RUN cycle
    run_add(16'hFFFF, 16'h0000, 1'b1, 1'b1, n, bn);
    check_eq("t2_busy_cycles", bn, 32'd4);

    // 3: signed overflow both directions
    run_add(16'h7FFF, 16'h0001, 1'b0, 1'b0, n, bn);
    run_add(16'h8000, 16'h8000, 1'b0, 1'b0, n, bn);

    // 4: start held through busy is ignored, then accepted in the done cycle
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; start = 1'b1;
    exp_q.push_back(model(16'h0001, 16'h0001, 1'b0));
    @(posedge clk); #1;
    a = 16'hAAAA;
    wait_done(1'b0, n, bn);
    check_eq("t4_first_latency", n - 1, 32'd4);
    exp_q.push_back(model(16'hAAAA, 16'h0001, 1'b0));
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("t4_reaccept_busy", {31'b0, busy}, 32'd1);
    wait_done(1'b0, n, bn);
    check_eq("t4_second_latency", n - 1, 32'd4);

    // 5: asynchronous reset mid-operation
    @(posedge clk); #1;
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    check_eq("t5_busy", {31'b0, busy}, 32'd0);
    check_eq("t5_done", {31'b0, done}, 32'd0);
    check_eq("t5_sum",  {16'b0, sum},  32'd0);
    check_eq("t5_cout_ovf", {30'b0, cout, ovf}, 32'd0);
    check_eq("t5_addin", {23'b0, add_a, add_b, add_cin}, 32'd0);
    #3;
    reset = 1'b0;
    run_add(16'h0F0F, 16'h00F1, 1'b0, 1'b0, n, bn);
    check_eq("t5_latency", n - 1, 32'd4);

    // 6: random operands against the reference model
    for (int i = 0; i < 10; i++) begin
      run_add(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, n, bn);
    end

    @(negedge clk);
    check_eq("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_serial_add_ctrl.md
Name: nibble_serial_add_ctrl

Overview:
Sequencing controller that performs a WIDTH-bit add by time-multiplexing one external 4-bit ripple adder (fulladder4b) over NIBBLES cycles, LSB nibble first, chaining the carry through a register. Sits between a requester (start/done handshake) and the shared fulladder4b datapath. Produces the full sum, carry-out and a signed-overflow flag.

Parameters:
NIBBLES, 4, number of 4-bit slices; operand width WIDTH = 4*NIBBLES; legal range 2..16.

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
start  input  1  request; sampled only when idle (busy=0)
a  input  WIDTH  operand A, captured on accepted start
b  input  WIDTH  operand B, captured on accepted start
cin  input  1  carry-in, captured on accepted start
busy  output  1  high while an add is in progress
done  output  1  one-cycle pulse: result valid
sum  output  WIDTH  registered result, held until next accepted start
cout  output  1  registered carry-out of MSB nibble
ovf  output  1  registered signed (two's-complement) overflow
add_a  output  4  nibble of A to adder
add_b  output  4  nibble of B to adder
add_cin  output  1  carry-in to adder
add_sum  input  4  adder sum (combinational return)
add_carry  input  1  adder carry (combinational return)

Behaviour:
- Reset (async, any state): state=IDLE, busy=0, done=0, sum=0, cout=0, ovf=0, idx=0, carry_reg=0, operand regs=0. Takes effect without a clock edge.
- States: IDLE, RUN. No other states.
- IDLE: add_a=0, add_b=0, add_cin=0. If start=1 at edge: latch a, b, cin; sum<=0; idx<=0; state<=RUN; busy<=1. done deasserts at that edge.
- RUN: add_a=a_reg[4*idx+:4], add_b=b_reg[4*idx+:4], add_cin = (idx==0) ? cin_reg : carry_reg (combinational from registers, not from add_carry).
- Each RUN edge: sum[4*idx+:4]<=add_sum; carry_reg<=add_carry; idx<=idx+1.
- Edge with idx==NIBBLES-1: additionally cout<=add_carry; ovf<=(a_reg[MSB]==b_reg[MSB]) && (add_sum[3]!=a_reg[MSB]); state<=IDLE; busy<=0; done<=1; idx<=0.
- Latency: start accepted at edge E0 -> done=1 and final sum/cout/ovf visible after edge E_NIBBLES, for exactly one cycle. busy high for exactly NIBBLES cycles.
- done is a single-cycle pulse; deasserts at next edge regardless of start.
- start during busy: ignored; a/b/cin changes during busy have no effect (operands latched).
- start in the done cycle (state IDLE): accepted; back-to-back throughput = one result per NIBBLES cycles.
- sum/cout/ovf hold last result in IDLE until next accepted start; sum cleared at accept, partial nibbles visible during RUN (not valid until done).
- idx width = clog2(NIBBLES); never exceeds NIBBLES-1.
- Adder modelled as purely combinational; controller places no timing assumption beyond single-cycle settle.

Test Plan:
(bench instantiates fulladder4b wired to add_*; NIBBLES=4)
1. a=16'h1234, b=16'h4321, cin=0, start pulse -> busy 4 cycles, done pulse after 4th edge, sum=16'h5555, cout=0, ovf=0.
2. a=16'hFFFF, b=16'h0000, cin=1 -> carry ripples all nibbles; sum=16'h0000, cout=1, ovf=0; add_cin=1 in every RUN cycle.
3. a=16'h7FFF, b=16'h0001, cin=0 -> sum=16'h8000, cout=0, ovf=1; then a=16'h8000, b=16'h8000 -> sum=16'h0000, cout=1, ovf=1.
4. Accept a=16'h0001, b=16'h0001; hold start=1 with a=16'hAAAA during busy -> ignored, result sum=16'h0002; start held into done cycle -> second add (16'hAAAA+b) accepted immediately, done 4 cycles later.
5. Assert reset mid-operation (after 2nd RUN edge, off clock edge) -> busy, done, sum, cout, ovf, add_* all 0 immediately; after release, a=16'h0F0F, b=16'h00F1 -> sum=16'h1000, cout=0.
6. Randomised 10 operand sets (a, b, cin from $random) -> sum/cout match a+b+cin reference model; ovf matches sign rule.
